arch_reg_dump_ctrl: RTL and testbench
=====================================

ARCH_REG_DUMP_CTRL -- requirements
Module: arch_reg_dump_ctrl

Interface
REQ-001 Parameter ARCH_REG_NUM, default 32, SHALL set the number of architectural registers walked per dump.
REQ-002 Parameter ARCH_REG_NUM_WIDTH, default 5, SHALL set the register index width.
REQ-003 Parameter REG_VAL_WIDTH, default 32, SHALL set the register value width.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum WAIT cycles allowed per read.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-007 finish  input  1  SHALL be the CPU end-of-program indication.
REQ-008 rd_en  output  1  SHALL be the read request to the CPU's ARCH_REG_READ_IF slave.
REQ-009 read_red_addr_req  output  ARCH_REG_NUM_WIDTH  SHALL be the requested architectural register index.
REQ-010 read_valid  input  1  SHALL indicate that read_value is valid for the pending request.
REQ-011 read_value  input  REG_VAL_WIDTH  SHALL be the returned register value.
REQ-012 dump_valid  output  1  SHALL flag a valid dump record.
REQ-013 dump_ready  input  1  SHALL be consumer back-pressure.
REQ-014 dump_idx  output  ARCH_REG_NUM_WIDTH  SHALL be the register index of the record.
REQ-015 dump_data  output  REG_VAL_WIDTH  SHALL be the register value of the record.
REQ-016 dump_last  output  1  SHALL be high with the record for index ARCH_REG_NUM-1.
REQ-017 busy  output  1  SHALL be high in any state other than IDLE and DONE.
REQ-018 done  output  1  SHALL be high in DONE.
REQ-019 err  output  1  SHALL be a sticky flag set on any read timeout.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT, OUT, DONE; every output SHALL be driven from registered state/data.
REQ-021 finish SHALL be registered once; a rising edge is finish high while the registered copy is low.
REQ-022 IDLE: a finish rising edge SHALL load idx=0, clear err, and enter REQ; otherwise remain in IDLE.
REQ-023 Finish edges outside IDLE SHALL be ignored.
REQ-024 REQ: rd_en=1 and read_red_addr_req=idx; the next state SHALL unconditionally be WAIT with the timeout counter cleared.
REQ-025 WAIT: rd_en=1 and the address SHALL be held.
REQ-026 WAIT: read_valid=1 SHALL capture read_value into dump_data, set dump_idx=idx, drop rd_en, and enter OUT.
REQ-027 read_valid SHALL be ignored outside WAIT.
REQ-028 WAIT timeout: if the counter reaches TIMEOUT_CYCLES-1 without read_valid, the block SHALL capture dump_data=0, set err=1, and enter OUT.
REQ-029 If read_valid arrives in the timeout cycle, the valid data SHALL win and err SHALL be unchanged.
REQ-030 OUT: dump_valid=1; dump_idx, dump_data and dump_last SHALL stay stable until dump_valid && dump_ready.
REQ-031 OUT handshake: idx==ARCH_REG_NUM-1 SHALL enter DONE; otherwise idx+1 SHALL enter REQ.
REQ-032 idx SHALL never wrap past ARCH_REG_NUM-1.
REQ-033 DONE: done=1 and all other outputs SHALL be 0 except err; finish low SHALL return the block to IDLE.
REQ-034 With read_valid on the first WAIT cycle and dump_ready tied high, each register SHALL take exactly 3 cycles (REQ, WAIT, OUT), giving 3*ARCH_REG_NUM cycles from REQ entry to DONE entry.

Reset
REQ-035 reset=0 at a rising edge SHALL force IDLE and clear idx, the timeout counter, the registered finish, dump_idx, dump_data and err.
REQ-036 During and after reset, rd_en, read_red_addr_req, dump_valid, dump_last, busy and done SHALL all be 0.
REQ-037 Reset in any state, including mid-dump, SHALL abort the walk with no further records; a new finish rising edge is required to restart.

Verification
REQ-038 Scenario: read_valid returns one cycle after each request, dump_ready=1, finish rises -> 32 records idx 0..31 with data matching the model, dump_last only on idx 31, done asserted 96 cycles after REQ entry, err=0.
REQ-039 Scenario: dump_ready toggled randomly -> no record is lost or duplicated, and dump_idx/dump_data stay stable while stalled.
REQ-040 Scenario: read_valid withheld for register 5 -> record idx 5 carries data 0 after 64 WAIT cycles, err=1 stays set, and the walk completes through idx 31.
REQ-041 Scenario: reset driven low during OUT of idx 10 -> next cycle all outputs are 0 and state is IDLE; a new finish edge restarts the walk at idx 0.
REQ-042 Scenario: finish held high after DONE, then pulsed again -> no restart while held; DONE→IDLE on finish low; the next rising edge starts a fresh dump.

Source files
------------

// File: rtl/arch_reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// arch_reg_dump_ctrl
//
// After the CPU signals end-of-program, walks every architectural register
// through the CPU's register-read slave and streams one dump record per
// register over a valid/ready interface. A read that never returns is given
// up after a bounded number of wait cycles, recorded as zero, and flagged in
// a sticky error bit.
//
// Ports
//   clk               single clock, rising edge
//   reset             synchronous, active-low reset
//   finish            CPU end-of-program indication (walk starts on rising edge)
//   rd_en             read request to the register-read slave
//   read_red_addr_req register index being requested
//   read_valid        read_value is valid for the pending request
//   read_value        returned register value
//   dump_valid        dump record valid
//   dump_ready        consumer back-pressure
//   dump_idx          register index of the record
//   dump_data         register value of the record (0 on a timed-out read)
//   dump_last         record is for the final register
//   busy              walk in progress
//   done              walk complete, waiting for finish to drop
//   err               sticky: at least one read timed out in this walk
// -----------------------------------------------------------------------------
module arch_reg_dump_ctrl #(
  parameter int ARCH_REG_NUM       = 32,
  parameter int ARCH_REG_NUM_WIDTH = 5,
  parameter int REG_VAL_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          finish,
  output logic                          rd_en,
  output logic [ARCH_REG_NUM_WIDTH-1:0] read_red_addr_req,
  input  logic                          read_valid,
  input  logic [REG_VAL_WIDTH-1:0]      read_value,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [ARCH_REG_NUM_WIDTH-1:0] dump_idx,
  output logic [REG_VAL_WIDTH-1:0]      dump_data,
  output logic                          dump_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ARCH_REG_NUM_WIDTH-1:0] LAST_IDX = ARCH_REG_NUM_WIDTH'(ARCH_REG_NUM - 1);
  localparam logic [TO_W-1:0]               TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [ARCH_REG_NUM_WIDTH-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]                 to_cnt_q, to_cnt_d;
  logic                            finish_q;
  logic [ARCH_REG_NUM_WIDTH-1:0]   rec_idx_q, rec_idx_d;
  logic [REG_VAL_WIDTH-1:0]        rec_data_q, rec_data_d;
  logic                            err_q, err_d;

  logic finish_rise;
  assign finish_rise = finish && !finish_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      finish_q   <= 1'b0;
      rec_idx_q  <= '0;
      rec_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      finish_q   <= finish;
      rec_idx_q  <= rec_idx_d;
      rec_data_q <= rec_data_d;
      err_q      <= err_d;
    end
  end

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    rec_idx_d  = rec_idx_q;
    rec_data_d = rec_data_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (finish_rise) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // Valid data takes priority over a timeout landing in the same cycle.
        if (read_valid) begin
          rec_idx_d  = idx_q;
          rec_data_d = read_value;
          state_d    = S_OUT;
        end else if (to_cnt_q == TO_LAST) begin
          rec_idx_d  = idx_q;
          rec_data_d = '0;
          err_d      = 1'b1;
          state_d    = S_OUT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_OUT: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ARCH_REG_NUM_WIDTH'(1);
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        if (!finish) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the registered state; record fields are masked outside
  // OUT so IDLE and DONE present all-zero records.
  assign rd_en             = (state_q == S_REQ) || (state_q == S_WAIT);
  assign read_red_addr_req = rd_en ? idx_q : '0;
  assign dump_valid        = (state_q == S_OUT);
  assign dump_idx          = dump_valid ? rec_idx_q : '0;
  assign dump_data         = dump_valid ? rec_data_q : '0;
  assign dump_last         = dump_valid && (rec_idx_q == LAST_IDX);
  assign busy              = rd_en || dump_valid;
  assign done              = (state_q == S_DONE);
  assign err               = err_q;

endmodule

// File: tb/tb_arch_reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arch_reg_dump_ctrl
//
// Scoreboard bench: each walk pushes its expected records into a queue when
// it is launched; a monitor compares every presented record against the head
// of the queue (also while stalled) and pops on handshake. A small CPU model
// answers register reads with a per-register latency.
// -----------------------------------------------------------------------------
module tb_arch_reg_dump_ctrl;

  localparam int N  = 32;
  localparam int W  = 5;
  localparam int V  = 32;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         finish = 1'b0;
  logic         rd_en;
  logic [W-1:0] read_red_addr_req;
  logic         read_valid = 1'b0;
  logic [V-1:0] read_value = '0;
  logic         dump_valid;
  logic         dump_ready = 1'b1;
  logic [W-1:0] dump_idx;
  logic [V-1:0] dump_data;
  logic         dump_last;
  logic         busy;
  logic         done;
  logic         err;

  arch_reg_dump_ctrl #(
    .ARCH_REG_NUM      (N),
    .ARCH_REG_NUM_WIDTH(W),
    .REG_VAL_WIDTH     (V),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .finish           (finish),
    .rd_en            (rd_en),
    .read_red_addr_req(read_red_addr_req),
    .read_valid       (read_valid),
    .read_value       (read_value),
    .dump_valid       (dump_valid),
    .dump_ready       (dump_ready),
    .dump_idx         (dump_idx),
    .dump_data        (dump_data),
    .dump_last        (dump_last),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] idx;
    logic [V-1:0] data;
    logic         last;
  } rec_t;

  rec_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // CPU model / consumer configuration
  int          base_lat   = 1;
  int          slow_idx   = -1;
  int          slow_lat   = 0;
  bit          rand_ready = 1'b0;
  bit          noise      = 1'b0;
  logic [V-1:0] salt      = '0;
  int          rd_wait    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [V-1:0] model(input logic [W-1:0] a);
    return salt ^ (32'h9E37_79B9 * (32'(a) + 32'd1));
  endfunction

  // CPU read slave, consumer ready and record monitor, all on the falling edge.
  always @(negedge clk) begin
    int lat;
    lat = (int'(read_red_addr_req) == slow_idx) ? slow_lat : base_lat;
    if (rd_en && rd_wait >= lat) begin
      read_valid = 1'b1;
      read_value = model(read_red_addr_req);
    end else if (!rd_en && noise) begin
      read_valid = 1'($urandom_range(0, 1));
      read_value = $urandom;
    end else begin
      read_valid = 1'b0;
      read_value = $urandom;
    end
    rd_wait = rd_en ? rd_wait + 1 : 0;

    dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    if (dump_valid) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("dump_idx",  64'(dump_idx),  64'(exp_q[0].idx));
        check("dump_data", 64'(dump_data), 64'(exp_q[0].data));
        check("dump_last", 64'(dump_last), 64'(exp_q[0].last));
        if (dump_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_walk(input int to_idx, input int n);
    salt = $urandom;
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r.idx  = W'(i);
      r.data = (i == to_idx) ? '0 : model(W'(i));
      r.last = (i == N - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rd_en"},  64'(rd_en), 64'(0));
    check({tag, "_addr"},   64'(read_red_addr_req), 64'(0));
    check({tag, "_valid"},  64'(dump_valid), 64'(0));
    check({tag, "_idx"},    64'(dump_idx), 64'(0));
    check({tag, "_data"},   64'(dump_data), 64'(0));
    check({tag, "_last"},   64'(dump_last), 64'(0));
    check({tag, "_busy"},   64'(busy), 64'(0));
  endtask

  task automatic start_walk();
    @(negedge clk) finish = 1'b1;
    @(negedge clk);
    check("start_rd_en", 64'(rd_en), 64'(1));
    check("start_addr",  64'(read_red_addr_req), 64'(0));
    check("start_err",   64'(err), 64'(0));
  endtask

  task automatic wait_done(output int cyc, input int limit);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_done", 64'(done), 64'(1));
  endtask

  task automatic end_walk();
    @(negedge clk) finish = 1'b0;
    @(negedge clk);
    check("done_to_idle", 64'(done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_done", 64'(done), 64'(0));
    check("reset_err",  64'(err),  64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    // Basic walk: one-cycle read latency, ready tied high
    push_walk(-1, N);
    start_walk();
    wait_done(cyc, 500);
    check("basic_cycles", 64'(cyc), 64'(3 * N));
    check("basic_err",    64'(err), 64'(0));
    check_quiet("basic_done");
    check("basic_sb_empty", 64'(exp_q.size()), 64'(0));
    end_walk();

    // Reset during OUT of idx 10 aborts the walk
    push_walk(-1, 11);
    start_walk();
    cyc = 0;
    while (!(dump_valid && dump_idx == W'(10)) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_idx10", 64'(dump_valid && dump_idx == W'(10)), 64'(1));
    reset  = 1'b0;
    finish = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    check("abort_done", 64'(done), 64'(0));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_restart", 64'(busy), 64'(0));
    check("abort_sb_empty",   64'(exp_q.size()), 64'(0));
    push_walk(-1, N);
    start_walk();
    wait_done(cyc, 500);
    check("restart_cycles",   64'(cyc), 64'(3 * N));
    check("restart_sb_empty", 64'(exp_q.size()), 64'(0));

    // finish held high in DONE: no restart until it drops and rises again
    repeat (10) @(negedge clk);
    check("hold_done",  64'(done),  64'(1));
    check("hold_busy",  64'(busy),  64'(0));
    check("hold_rd_en", 64'(rd_en), 64'(0));
    end_walk();
    repeat (3) @(negedge clk);
    check("idle_after_done", 64'(busy), 64'(0));

    // Random back-pressure, longer latency, read_valid noise outside requests
    rand_ready = 1'b1;
    noise      = 1'b1;
    base_lat   = 2;
    push_walk(-1, N);
    start_walk();
    wait_done(cyc, 3000);
    check("rand_sb_empty", 64'(exp_q.size()), 64'(0));
    check("rand_err",      64'(err), 64'(0));
    end_walk();
    rand_ready = 1'b0;
    noise      = 1'b0;
    base_lat   = 1;

    // Register 5 never answers: timeout record, sticky err, walk completes
    slow_idx = 5;
    slow_lat = 100000;
    push_walk(5, N);
    start_walk();
    wait_done(cyc, 1000);
    check("to_cycles",   64'(cyc), 64'(3 * N + TO - 1));
    check("to_err",      64'(err), 64'(1));
    check("to_sb_empty", 64'(exp_q.size()), 64'(0));
    end_walk();
    check("to_err_sticky", 64'(err), 64'(1));

    // Register 7 answers exactly in the timeout cycle: data wins, no err
    slow_idx = 7;
    slow_lat = TO;
    push_walk(-1, N);
    start_walk();
    wait_done(cyc, 1000);
    check("edge_cycles",   64'(cyc), 64'(3 * N + TO - 1));
    check("edge_err",      64'(err), 64'(0));
    check("edge_sb_empty", 64'(exp_q.size()), 64'(0));
    end_walk();
    slow_idx = -1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
